aes_decryptor_ip_buffer: RTL and testbench

Receive-side input buffer for the AES decryption core, the counterpart of the encryptor output buffer. It accepts the serial cipher bitstream from the OFDM receiver front-end and reassembles it into 128-bit blocks. Completed blocks are queued in a block FIFO and presented to the decryptor as a NO_ROWS×NO_COLS byte state matrix with a valid/ready handshake. The OFDM receive data is already synchronised into the AES clock domain upstream, so the block runs on one clock.

---
 rtl/aes_buf_pkg.sv | 29 ++
 rtl/aes_blk_fifo.sv | 63 ++++++
 rtl/aes_decryptor_ip_buffer.sv | 178 +++++++++++++++++
 tb/tb_aes_decryptor_ip_buffer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_buf_pkg.sv
// Shared types and helpers for the AES decryptor input buffer:
// block size, byte-matrix typedef, deserializer state encoding and the
// stream-byte to column-major matrix index mapping.
package aes_buf_pkg;

    localparam int DEF_ROWS = 4;
    localparam int DEF_COLS = 4;

    // Bits in one AES block for a given state-matrix shape.
    function automatic int block_bits(input int rows, input int cols);
        return 8 * rows * cols;
    endfunction

    // Default-shape state matrix: [row][col] of bytes.
    typedef logic [DEF_ROWS-1:0][DEF_COLS-1:0][7:0] state_mat_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        STALL   = 2'd2
    } deser_state_e;

    // Stream byte k lands at row k%rows, column k/rows; returns the flat
    // byte slot (row*cols + col) inside a packed [row][col][7:0] matrix.
    function automatic int mat_byte_idx(input int k, input int rows, input int cols);
        return (k % rows) * cols + (k / rows);
    endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// Single-clock block FIFO with registered full/empty/level flags.
// Pointers wrap modulo DEPTH (power of two); a push while full is only
// honoured when a pop happens in the same cycle.
module aes_blk_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;
    logic [AW:0]      level_n;

    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    // Next occupancy; simultaneous push and pop leaves it unchanged.
    always_comb begin
        level_n = level + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
    end

    // Storage array, written at the write pointer.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            level <= level_n;
            full  <= (level_n == (AW+1)'(DEPTH));
            empty <= (level_n == '0);
        end
    end

    // Head is forced to zero when empty so no stale or unwritten data shows.
    assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/aes_decryptor_ip_buffer.sv
// Receive-side AES input buffer: deserializes the OFDM cipher bitstream
// (byte-wise MSB first) into 128-bit blocks, queues them in a block FIFO
// and presents the head as a column-major byte state matrix.
// Optional feature macro: AES_DEC_IP_BUF_TIMEOUT_EN (partial-block idle flush).
//
// Handshakes: a transfer happens on a rising edge where valid && ready;
// valid never waits for ready, and ready is a function of registered
// state only (no combinational path from cipher_txt_rdy to ofdm_sdata_rdy).
module aes_decryptor_ip_buffer
    import aes_buf_pkg::*;
#(
    parameter int BUF_SIZE       = 2048,
    parameter int NO_ROWS        = 4,
    parameter int NO_COLS        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                            aes_clk,
    input  logic                                            reset,
    input  logic                                            ofdm_sdata_vld,
    output logic                                            ofdm_sdata_rdy,
    input  logic                                            ofdm_sdata,
    output logic                                            cipher_txt_vld,
    input  logic                                            cipher_txt_rdy,
    output logic [NO_ROWS-1:0][NO_COLS-1:0][7:0]            p_cipher_txt,
    output logic [$clog2(BUF_SIZE/block_bits(NO_ROWS, NO_COLS)):0] buf_level,
    output logic                                            err_timeout
);

    localparam int BLOCK_BITS = block_bits(NO_ROWS, NO_COLS);
    localparam int NO_BYTES   = NO_ROWS * NO_COLS;
    localparam int DEPTH      = BUF_SIZE / BLOCK_BITS;
    localparam int CNT_W      = $clog2(BLOCK_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BLOCK_BITS - 1);

    deser_state_e            state;
    deser_state_e            state_n;
    logic [CNT_W-1:0]        bit_cnt;
    logic [CNT_W-1:0]        bit_cnt_n;
    logic                    live;
    logic [BLOCK_BITS-2:0]   shreg;
    logic [BLOCK_BITS-1:0]   stream_blk;
    logic [BLOCK_BITS-1:0]   mat_blk;
    logic [BLOCK_BITS-1:0]   head;
    logic                    accept;
    logic                    push;
    logic                    pop;
    logic                    last_blocked;
    logic                    timeout_hit;
    logic                    fifo_full;
    logic                    fifo_empty;

    // Last bit pending while the FIFO has no room: hold the sender off.
    assign last_blocked   = (bit_cnt == LAST_BIT) && fifo_full;
    assign ofdm_sdata_rdy = live && (state != STALL) && !last_blocked;
    assign accept         = ofdm_sdata_vld && ofdm_sdata_rdy;

    assign cipher_txt_vld = !fifo_empty;
    assign pop            = cipher_txt_vld && cipher_txt_rdy;
    assign p_cipher_txt   = head;

    // Complete block in arrival order: stream bit 0 ends up as the MSB.
    assign stream_blk = {shreg, ofdm_sdata};

    // Pure rewiring of stream byte k into its column-major matrix slot.
    always_comb begin
        mat_blk = '0;
        for (int k = 0; k < NO_BYTES; k++) begin
            mat_blk[mat_byte_idx(k, NO_ROWS, NO_COLS)*8 +: 8] = stream_blk[BLOCK_BITS-1-8*k -: 8];
        end
    end

    // Deserializer next-state logic.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        push      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n   = COLLECT;
                    bit_cnt_n = CNT_W'(1);
                end
            end
            COLLECT: begin
                if (last_blocked) begin
                    state_n = STALL;
                end else if (accept) begin
                    if (bit_cnt == LAST_BIT) begin
                        push      = 1'b1;
                        state_n   = IDLE;
                        bit_cnt_n = '0;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_n   = IDLE;
                    bit_cnt_n = '0;
                end
            end
            STALL: begin
                if (!fifo_full) state_n = COLLECT;
            end
            default: begin
                state_n   = IDLE;
                bit_cnt_n = '0;
            end
        endcase
    end

    // State, bit counter and the post-reset ready enable.
    always_ff @(posedge aes_clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            live    <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            live    <= 1'b1;
        end
    end

    // Serial shift register collecting the first BLOCK_BITS-1 bits.
    always_ff @(posedge aes_clk or posedge reset) begin
        if (reset) begin
            shreg <= '0;
        end else if (accept) begin
            shreg <= {shreg[BLOCK_BITS-3:0], ofdm_sdata};
        end
    end

`ifdef AES_DEC_IP_BUF_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [IDLE_W-1:0] idle_cnt;

    assign timeout_hit = (state == COLLECT) && !accept && !last_blocked &&
                         (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

    // Idle counter: runs only in COLLECT without a bit, cleared otherwise.
    always_ff @(posedge aes_clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if ((state != COLLECT) || accept || timeout_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // One-cycle flush indication.
    always_ff @(posedge aes_clk or posedge reset) begin
        if (reset) begin
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= timeout_hit;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    aes_blk_fifo #(
        .WIDTH (BLOCK_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (aes_clk),
        .rst   (reset),
        .push  (push),
        .din   (mat_blk),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (buf_level)
    );

endmodule

// File: tb/tb_aes_decryptor_ip_buffer.sv
// Self-checking bench for aes_decryptor_ip_buffer (4x4 matrix, 16-block FIFO,
// TIMEOUT_CYCLES = 8). Build with AES_DEC_IP_BUF_TIMEOUT_EN to cover the flush.
module tb_aes_decryptor_ip_buffer;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int NB   = 16;
    localparam int BITS = 128;

    typedef logic [ROWS-1:0][COLS-1:0][7:0] mat_t;
    typedef logic [NB-1:0][7:0] bytes_t;
    typedef struct {
        logic [7:0] base;
        logic [7:0] step;
        logic [7:0] r1c0;
        logic [7:0] r0c1;
        logic [7:0] r2c1;
        logic [7:0] r3c3;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic aes_clk        = 1'b0;
    logic reset          = 1'b1;
    logic ofdm_sdata_vld = 1'b0;
    logic ofdm_sdata     = 1'b0;
    logic cipher_txt_rdy = 1'b0;
    logic ofdm_sdata_rdy;
    logic cipher_txt_vld;
    logic err_timeout;
    mat_t p_cipher_txt;
    logic [4:0] buf_level;

    always #5 aes_clk = ~aes_clk;

    aes_decryptor_ip_buffer #(
        .BUF_SIZE       (2048),
        .NO_ROWS        (ROWS),
        .NO_COLS        (COLS),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .aes_clk        (aes_clk),
        .reset          (reset),
        .ofdm_sdata_vld (ofdm_sdata_vld),
        .ofdm_sdata_rdy (ofdm_sdata_rdy),
        .ofdm_sdata     (ofdm_sdata),
        .cipher_txt_vld (cipher_txt_vld),
        .cipher_txt_rdy (cipher_txt_rdy),
        .p_cipher_txt   (p_cipher_txt),
        .buf_level      (buf_level),
        .err_timeout    (err_timeout)
    );

    // ---------------- scoreboard state ----------------
    logic [BITS-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected matrix: element [r][c] holds stream byte c*ROWS + r.
    function automatic mat_t to_mat(input bytes_t b);
        mat_t m;
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                m[r][c] = b[c*ROWS + r];
        return m;
    endfunction

    function automatic bytes_t ramp(input logic [7:0] base, input logic [7:0] step);
        bytes_t b;
        for (int k = 0; k < NB; k++) b[k] = base + 8'(k) * step;
        return b;
    endfunction

    function automatic bytes_t rand_bytes();
        bytes_t b;
        for (int k = 0; k < NB; k++) b[k] = 8'($urandom_range(0, 255));
        return b;
    endfunction

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 after the bit was taken.
    task automatic send_bit(input logic v);
        int guard;
        guard = 0;
        ofdm_sdata_vld = 1'b1;
        ofdm_sdata     = v;
        forever begin
            @(negedge aes_clk);
            if (ofdm_sdata_rdy) break;
            guard++;
            if (guard > 2000) begin
                chk("bit_accept_budget", 128'(ofdm_sdata_rdy), 128'd1);
                break;
            end
        end
        @(posedge aes_clk);
        #1;
        ofdm_sdata_vld = 1'b0;
    endtask

    // Sends stream bits lo..hi of block b (byte i/8, MSB first).
    task automatic send_range(input bytes_t b, input int lo, input int hi, input int gap_max);
        for (int i = lo; i <= hi; i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                @(posedge aes_clk);
                #1;
            end
            send_bit(b[i/8][7 - (i%8)]);
        end
    endtask

    task automatic send_block(input bytes_t b, input int gap_max);
        exp_q.push_back(to_mat(b));
        send_range(b, 0, BITS-1, gap_max);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        @(posedge aes_clk);
        #1;
        cipher_txt_rdy = 1'b1;
        forever begin
            @(negedge aes_clk);
            if (!cipher_txt_vld) break;
            guard++;
            if (guard > 64) begin
                chk("drain_budget", 128'(cipher_txt_vld), 128'd0);
                break;
            end
        end
        cipher_txt_rdy = 1'b0;
        @(posedge aes_clk);
        #1;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge aes_clk) begin
        if (!reset && cipher_txt_vld && cipher_txt_rdy) begin
            chk("sb_has_expected", 128'(exp_q.size() != 0), 128'd1);
            if (exp_q.size() != 0) chk("sb_block", p_cipher_txt, exp_q.pop_front());
        end
    end

    // ---------------- test sequence ----------------
    vec_t   vecs[4];
    bytes_t b;
    bytes_t b2;
    int     pulses;
    int     pulse_at;
    logic   drv_done;

    initial begin
        vecs[0] = '{8'h00, 8'h01, 8'h01, 8'h04, 8'h06, 8'h0F};
        vecs[1] = '{8'h10, 8'h11, 8'h21, 8'h54, 8'h76, 8'h0F};
        vecs[2] = '{8'hA5, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
        vecs[3] = '{8'hF0, 8'h03, 8'hF3, 8'hFC, 8'h02, 8'h1D};

        // Reset values
        repeat (3) @(posedge aes_clk);
        #1;
        chk("rst_sdata_rdy", 128'(ofdm_sdata_rdy), 128'd0);
        chk("rst_txt_vld",   128'(cipher_txt_vld), 128'd0);
        chk("rst_matrix",    p_cipher_txt, 128'd0);
        chk("rst_level",     128'(buf_level), 128'd0);
        chk("rst_err",       128'(err_timeout), 128'd0);
        reset = 1'b0;
        @(negedge aes_clk);
        chk("rdy_before_edge", 128'(ofdm_sdata_rdy), 128'd0);
        @(posedge aes_clk);
        #1;
        chk("rdy_after_edge", 128'(ofdm_sdata_rdy), 128'd1);

        // Table-driven single blocks
        for (int i = 0; i < 4; i++) begin
            b = ramp(vecs[i].base, vecs[i].step);
            chk("vec_pre_vld", 128'(cipher_txt_vld), 128'd0);
            send_block(b, (i == 3) ? 2 : 0);
            chk("vec_vld",   128'(cipher_txt_vld), 128'd1);
            chk("vec_level", 128'(buf_level), 128'd1);
            chk("vec_r1c0",  128'(p_cipher_txt[1][0]), 128'(vecs[i].r1c0));
            chk("vec_r0c1",  128'(p_cipher_txt[0][1]), 128'(vecs[i].r0c1));
            chk("vec_r2c1",  128'(p_cipher_txt[2][1]), 128'(vecs[i].r2c1));
            chk("vec_r3c3",  128'(p_cipher_txt[3][3]), 128'(vecs[i].r3c3));
            drain();
            chk("vec_level_empty", 128'(buf_level), 128'd0);
        end

        // Fill to 16, stall on the 17th block's last bit, release with one pop
        cipher_txt_rdy = 1'b0;
        for (int i = 0; i < 16; i++) send_block(ramp(8'(i*16), 8'h01), 0);
        chk("full_level", 128'(buf_level), 128'd16);
        b = ramp(8'hC0, 8'h05);
        exp_q.push_back(to_mat(b));
        send_range(b, 0, BITS-2, 0);
        ofdm_sdata_vld = 1'b1;
        ofdm_sdata     = b[NB-1][0];
        @(negedge aes_clk);
        chk("stall_rdy_low", 128'(ofdm_sdata_rdy), 128'd0);
        repeat (3) @(negedge aes_clk);
        chk("stall_rdy_hold", 128'(ofdm_sdata_rdy), 128'd0);
        chk("stall_level",    128'(buf_level), 128'd16);
        @(posedge aes_clk);
        #1;
        cipher_txt_rdy = 1'b1;
        @(posedge aes_clk);
        #1;
        cipher_txt_rdy = 1'b0;
        chk("pop_level",     128'(buf_level), 128'd15);
        chk("pop_still_stl", 128'(ofdm_sdata_rdy), 128'd0);
        @(posedge aes_clk);
        #1;
        chk("rdy_returns", 128'(ofdm_sdata_rdy), 128'd1);
        @(posedge aes_clk);
        #1;
        ofdm_sdata_vld = 1'b0;
        chk("blk17_stored", 128'(buf_level), 128'd16);

        // Block 18: final bit accepted in the same cycle as a pop
        b = ramp(8'h3C, 8'h07);
        exp_q.push_back(to_mat(b));
        send_range(b, 0, BITS-2, 0);
        ofdm_sdata_vld = 1'b1;
        ofdm_sdata     = b[NB-1][0];
        cipher_txt_rdy = 1'b1;
        @(posedge aes_clk);
        #1;
        cipher_txt_rdy = 1'b0;
        chk("pp_level_a", 128'(buf_level), 128'd15);
        chk("pp_rdy_low", 128'(ofdm_sdata_rdy), 128'd0);
        @(posedge aes_clk);
        #1;
        chk("pp_rdy_high", 128'(ofdm_sdata_rdy), 128'd1);
        chk("pp_level_b",  128'(buf_level), 128'd15);
        cipher_txt_rdy = 1'b1;
        @(posedge aes_clk);
        #1;
        cipher_txt_rdy = 1'b0;
        ofdm_sdata_vld = 1'b0;
        chk("pp_level_kept", 128'(buf_level), 128'd15);
        drain();
        chk("full_drained", 128'(exp_q.size()), 128'd0);

        // Partial block followed by idle time
        cipher_txt_rdy = 1'b0;
        b = rand_bytes();
        send_range(b, 0, 39, 0);
        pulses   = 0;
        pulse_at = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge aes_clk);
            if (err_timeout) begin
                pulses++;
                pulse_at = i;
            end
        end
`ifdef AES_DEC_IP_BUF_TIMEOUT_EN
        chk("to_pulses", 128'(pulses), 128'd1);
        chk("to_cycle",  128'(pulse_at), 128'd9);
        chk("to_level",  128'(buf_level), 128'd0);
        @(posedge aes_clk);
        #1;
        send_block(ramp(8'h5A, 8'h0B), 0);
`else
        chk("no_to_pulse", 128'(pulses), 128'd0);
        chk("held_level",  128'(buf_level), 128'd0);
        @(posedge aes_clk);
        #1;
        exp_q.push_back(to_mat(b));
        send_range(b, 40, BITS-1, 0);
`endif
        chk("after_partial_level", 128'(buf_level), 128'd1);
        drain();

        // Reset mid-block with an unread block queued
        send_block(ramp(8'h81, 8'h02), 0);
        b2 = rand_bytes();
        send_range(b2, 0, 69, 0);
        chk("pre_reset_level", 128'(buf_level), 128'd1);
        reset = 1'b1;
        exp_q.delete();
        @(negedge aes_clk);
        chk("mid_rst_sdata_rdy", 128'(ofdm_sdata_rdy), 128'd0);
        chk("mid_rst_vld",       128'(cipher_txt_vld), 128'd0);
        chk("mid_rst_matrix",    p_cipher_txt, 128'd0);
        chk("mid_rst_level",     128'(buf_level), 128'd0);
        chk("mid_rst_err",       128'(err_timeout), 128'd0);
        @(posedge aes_clk);
        #1;
        reset = 1'b0;
        @(posedge aes_clk);
        #1;
        chk("post_rst_rdy", 128'(ofdm_sdata_rdy), 128'd1);
        send_block(ramp(8'h17, 8'h1D), 0);
        chk("post_rst_level", 128'(buf_level), 128'd1);
        drain();

        // Random throttling on both sides
        drv_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 100; n++) begin
                    b = rand_bytes();
                    send_block(b, 2);
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge aes_clk);
                    #1;
                    cipher_txt_rdy = 1'($urandom_range(0, 1));
                end
            end
        join
        cipher_txt_rdy = 1'b0;
        drain();
        chk("random_drained", 128'(exp_q.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
